data_memory_responder: RTL

//  Bus-side responder for the core's data memory port: accepts lane-shifted write data plus byte enables,

---
 rtl/data_memory_responder_if.sv | 21 ++
 rtl/data_memory_responder.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/data_memory_responder_if.sv
// Data memory bus between the core-side master and the data RAM responder.
// The master drives the request fields; the responder returns full read words.
interface data_memory_responder_if;
  logic [31:0] bus_address;
  logic [31:0] bus_write_data;
  logic [3:0]  bus_byte_enable;
  logic        bus_read_enable;
  logic        bus_write_enable;
  logic [31:0] bus_read_data;
  logic        bus_read_valid;

  modport master (
    output bus_address, bus_write_data, bus_byte_enable, bus_read_enable, bus_write_enable,
    input  bus_read_data, bus_read_valid
  );

  modport slave (
    input  bus_address, bus_write_data, bus_byte_enable, bus_read_enable, bus_write_enable,
    output bus_read_data, bus_read_valid
  );
endinterface

// File: rtl/data_memory_responder.sv
// Data memory responder: byte-enabled word RAM with a fixed-latency read pipeline
// and sticky capture of misaligned / out-of-range accesses.
module data_memory_responder #(
  parameter logic [31:0] BASE_ADDR    = 32'h1001_0000,
  parameter int          DEPTH_WORDS  = 1024,
  parameter int          READ_LATENCY = 1
) (
  input  logic                   i_clock,
  input  logic                   i_reset_n,
  data_memory_responder_if.slave bus,
  input  logic                   i_error_clear,
  output logic                   o_error_flag,
  output logic [1:0]             o_error_cause,
  output logic [31:0]            o_error_address,
  output logic [7:0]             o_fault_count
);
  localparam int          AW         = $clog2(DEPTH_WORDS);
  localparam logic [31:0] SPAN_BYTES = 32'(4 * DEPTH_WORDS);

  logic [31:0]   w_offset;
  logic [AW-1:0] w_index;
  logic          w_access;
  logic          w_in_range;
  logic          w_aligned;
  logic          w_fault;
  logic          w_wr_go;
  logic          w_rd_go;

  assign w_access = bus.bus_read_enable | bus.bus_write_enable;
  // Addresses below BASE_ADDR wrap to offsets far beyond the span.
  assign w_offset   = bus.bus_address - BASE_ADDR;
  assign w_in_range = (w_offset < SPAN_BYTES);
  assign w_index    = w_offset[AW+1:2];

  always_comb begin
    w_aligned = 1'b0;
    case ({bus.bus_byte_enable, bus.bus_address[1:0]})
      6'b0000_00, 6'b0000_01, 6'b0000_10, 6'b0000_11,
      6'b0001_00, 6'b0010_01, 6'b0100_10, 6'b1000_11,
      6'b0011_00, 6'b1100_10, 6'b1111_00: w_aligned = 1'b1;
      default:                            w_aligned = 1'b0;
    endcase
  end

  assign w_fault = w_access & (~w_in_range | ~w_aligned);
  assign w_wr_go = bus.bus_write_enable & ~w_fault;
  assign w_rd_go = bus.bus_read_enable & ~w_fault;

  // Word RAM; the read port samples the old word when a write hits the same index.
  logic [31:0] r_ram [DEPTH_WORDS];
  logic [31:0] r_ram_q;

  always_ff @(posedge i_clock) begin
    for (int i = 0; i < 4; i++) begin
      if (w_wr_go && bus.bus_byte_enable[i]) begin
        r_ram[w_index][8*i +: 8] <= bus.bus_write_data[8*i +: 8];
      end
    end
    if (w_rd_go) begin
      r_ram_q <= r_ram[w_index];
    end
  end

  logic r_pend_a;
  logic r_zero_a;

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_pend_a <= 1'b0;
      r_zero_a <= 1'b0;
    end else begin
      r_pend_a <= bus.bus_read_enable;
      r_zero_a <= w_fault;
    end
  end

  logic        w_src_pend;
  logic        w_src_zero;
  logic [31:0] w_src_q;

  generate
    if (READ_LATENCY == 2) begin : g_lat2
      logic        r_pend_b;
      logic        r_zero_b;
      logic [31:0] r_q_b;

      always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
          r_pend_b <= 1'b0;
          r_zero_b <= 1'b0;
          r_q_b    <= 32'h0;
        end else begin
          r_pend_b <= r_pend_a;
          r_zero_b <= r_zero_a;
          if (r_pend_a) begin
            r_q_b <= r_ram_q;
          end
        end
      end

      assign w_src_pend = r_pend_b;
      assign w_src_zero = r_zero_b;
      assign w_src_q    = r_q_b;
    end else begin : g_lat1
      assign w_src_pend = r_pend_a;
      assign w_src_zero = r_zero_a;
      assign w_src_q    = r_ram_q;
    end
  endgenerate

  logic        r_read_valid;
  logic [31:0] r_read_data;

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_read_valid <= 1'b0;
      r_read_data  <= 32'h0;
    end else begin
      r_read_valid <= w_src_pend;
      if (w_src_pend) begin
        r_read_data <= w_src_zero ? 32'h0 : w_src_q;
      end
    end
  end

  assign bus.bus_read_valid = r_read_valid;
  assign bus.bus_read_data  = r_read_data;

  logic        r_error_flag;
  logic [1:0]  r_error_cause;
  logic [31:0] r_error_address;
  logic [7:0]  r_fault_count;

  // A fault in the same cycle as a clear wins and is captured as the new first fault.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_error_flag    <= 1'b0;
      r_error_cause   <= 2'b00;
      r_error_address <= 32'h0;
      r_fault_count   <= 8'h0;
    end else begin
      if (w_fault && (!r_error_flag || i_error_clear)) begin
        r_error_flag    <= 1'b1;
        r_error_cause   <= {~w_aligned, ~w_in_range};
        r_error_address <= bus.bus_address;
      end else if (i_error_clear && !w_fault) begin
        r_error_flag  <= 1'b0;
        r_error_cause <= 2'b00;
      end
      if (w_fault && (r_fault_count != 8'hFF)) begin
        r_fault_count <= r_fault_count + 8'd1;
      end
    end
  end

  assign o_error_flag    = r_error_flag;
  assign o_error_cause   = r_error_cause;
  assign o_error_address = r_error_address;
  assign o_fault_count   = r_fault_count;
endmodule
